cdb_arbiter: RTL



---
 rtl/cdb_arbiter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the common data bus (CDB) between the three result producers of the
// out-of-order core: ALU (source 0), branch unit (source 1) and load/store
// buffer (source 2). Each producer pushes {tag, data} into a private 2-entry
// FIFO. A round-robin arbiter drains one result per cycle into a registered
// CDB broadcast. A synchronous flush discards every queued and outgoing result.
//
// Optional feature (compile-time macro CDB_ARB_BYPASS_EN):
//   When defined, a source whose FIFO is empty and which presents a valid,
//   non-zero-tag, accepted push is eligible in the same cycle. If it wins, the
//   input is loaded straight into the output register and is not queued.
//   When undefined, every result spends at least one cycle in its FIFO.
//
// Parameters:
//   TAG_WIDTH   ROB tag width; tag 0 is the free tag and is never broadcast
//   DATA_WIDTH  result data width
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   flush                         synchronous discard of all in-flight results
//   alu_/br_/ls_valid,tag,data    producer push request
//   alu_/br_/ls_ready             producer may push this cycle (combinational)
//   cdb_valid, cdb_tag, cdb_data  registered broadcast
//   cdb_src                       registered winning source (0 ALU, 1 BR, 2 LS)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  alu_valid,
    input  logic [TAG_WIDTH-1:0]  alu_tag,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,

    input  logic                  br_valid,
    input  logic [TAG_WIDTH-1:0]  br_tag,
    input  logic [DATA_WIDTH-1:0] br_data,
    output logic                  br_ready,

    input  logic                  ls_valid,
    input  logic [TAG_WIDTH-1:0]  ls_tag,
    input  logic [DATA_WIDTH-1:0] ls_data,
    output logic                  ls_ready,

    output logic                  cdb_valid,
    output logic [TAG_WIDTH-1:0]  cdb_tag,
    output logic [DATA_WIDTH-1:0] cdb_data,
    output logic [1:0]            cdb_src
);

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned DEPTH   = 2;

    // ------------------------------------------------------------------
    // Source vectors, indexed 0 ALU, 1 branch, 2 LSBuf
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]    in_valid;
    logic [TAG_WIDTH-1:0]  in_tag  [NUM_SRC];
    logic [DATA_WIDTH-1:0] in_data [NUM_SRC];

    assign in_valid   = {ls_valid, br_valid, alu_valid};
    assign in_tag[0]  = alu_tag;
    assign in_tag[1]  = br_tag;
    assign in_tag[2]  = ls_tag;
    assign in_data[0] = alu_data;
    assign in_data[1] = br_data;
    assign in_data[2] = ls_data;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAG_WIDTH-1:0]  fifo_tag_q  [NUM_SRC][DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag_d  [NUM_SRC][DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [NUM_SRC][DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [NUM_SRC][DEPTH];
    logic [1:0]            count_q     [NUM_SRC];
    logic [1:0]            count_d     [NUM_SRC];
    logic [NUM_SRC-1:0]    wr_ptr_q, wr_ptr_d;
    logic [NUM_SRC-1:0]    rd_ptr_q, rd_ptr_d;

    logic [1:0]            rr_ptr_q, rr_ptr_d;

    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q,  cdb_data_d;
    logic [1:0]            cdb_src_q,   cdb_src_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC-1:0]    push_req;   // accepted push carrying a real tag
    logic [NUM_SRC-1:0]    eligible;
    logic [NUM_SRC-1:0]    push_en;
    logic [NUM_SRC-1:0]    pop_en;
    logic [1:0]            rr_eff;
    logic                  win_valid;
    logic [1:0]            win_idx;
    logic                  win_bypass;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [1:0] next3(input logic [1:0] v);
        return (v >= 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Ready is not credited by a same-cycle pop: a full FIFO stays closed.
    always_comb begin
        src_ready = '0;
        push_req  = '0;
        eligible  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count_q[i] < 2'd2) && !flush;
            // Tag-0 pushes are handshaken but dropped on the floor.
            push_req[i]  = in_valid[i] && src_ready[i] && (in_tag[i] != '0);
`ifdef CDB_ARB_BYPASS_EN
            eligible[i]  = (count_q[i] != 2'd0) || push_req[i];
`else
            eligible[i]  = (count_q[i] != 2'd0);
`endif
        end
    end

    assign alu_ready = src_ready[0];
    assign br_ready  = src_ready[1];
    assign ls_ready  = src_ready[2];

    // Round-robin search starting at rr_ptr; an illegal pointer of 3 is
    // treated as 0.
    assign rr_eff = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;

    always_comb begin
        logic [1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = rr_eff;
        for (int unsigned n = 0; n < NUM_SRC; n++) begin
            if (!win_valid && !flush && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
            cand = next3(cand);
        end
    end

    // A winner with an empty FIFO can only be a same-cycle bypass candidate.
    assign win_bypass = win_valid && (count_q[win_idx] == 2'd0);

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        if (win_bypass) begin
            sel_tag  = in_tag[win_idx];
            sel_data = in_data[win_idx];
        end else begin
            sel_tag  = fifo_tag_q[win_idx][rd_ptr_q[win_idx]];
            sel_data = fifo_data_q[win_idx][rd_ptr_q[win_idx]];
        end
    end

    always_comb begin
        push_en = '0;
        pop_en  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pop_en[i]  = win_valid && !win_bypass && (win_idx == i[1:0]);
            push_en[i] = push_req[i] && !(win_bypass && (win_idx == i[1:0]));
        end
    end

    // ------------------------------------------------------------------
    // FIFO next state. Push writes at wr_ptr while pop advances rd_ptr, so
    // a count-1 FIFO hands out its old head and the new entry becomes head.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_tag_d  = fifo_tag_q;
        fifo_data_d = fifo_data_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (flush) begin
                count_d[i]  = '0;
                wr_ptr_d[i] = 1'b0;
                rd_ptr_d[i] = 1'b0;
            end else begin
                if (push_en[i]) begin
                    fifo_tag_d[i][wr_ptr_q[i]]  = in_tag[i];
                    fifo_data_d[i][wr_ptr_q[i]] = in_data[i];
                    wr_ptr_d[i]                 = ~wr_ptr_q[i];
                end
                if (pop_en[i]) begin
                    rd_ptr_d[i] = ~rd_ptr_q[i];
                end
                case ({push_en[i], pop_en[i]})
                    2'b10:   count_d[i] = count_q[i] + 2'd1;
                    2'b01:   count_d[i] = count_q[i] - 2'd1;
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and round-robin pointer. Without a winner (including
    // flush) the tag/data/src fields hold and only valid drops.
    // ------------------------------------------------------------------
    always_comb begin
        cdb_valid_d = win_valid;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_eff;
        if (win_valid) begin
            cdb_tag_d  = sel_tag;
            cdb_data_d = sel_data;
            cdb_src_d  = win_idx;
            rr_ptr_d   = next3(win_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_tag_q  <= '{default: '0};
            fifo_data_q <= '{default: '0};
            count_q     <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            fifo_tag_q  <= fifo_tag_d;
            fifo_data_q <= fifo_data_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule
